// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: bundles the instruction, ALU and result buses of alu_ctrl.
//   master : the environment (instruction source, ALU, result consumer)
//   slave  : the alu_ctrl controller
// Signals:
//   instr_valid/instr_ready/instr/imm       instruction handshake + immediate
//   alu_a/alu_b/alu_op  -> ALU, alu_out/alu_flags <- ALU ({ovf, neg, zero})
//   res_valid/res_ready/res_data/res_flags  result handshake
//   ovf_count                               saturating overflow counter
interface alu_ctrl_if #(parameter int BW = 16);
  logic          instr_valid;
  logic          instr_ready;
  logic [9:0]    instr;
  logic [BW-1:0] imm;
  logic [BW-1:0] alu_a;
  logic [BW-1:0] alu_b;
  logic [2:0]    alu_op;
  logic [BW:0]   alu_out;
  logic [2:0]    alu_flags;
  logic          res_valid;
  logic          res_ready;
  logic [BW:0]   res_data;
  logic [2:0]    res_flags;
  logic [7:0]    ovf_count;

  modport master (
    output instr_valid, instr, imm, alu_out, alu_flags, res_ready,
    input  instr_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_flags, ovf_count
  );

  modport slave (
    input  instr_valid, instr, imm, alu_out, alu_flags, res_ready,
    output instr_ready, alu_a, alu_b, alu_op, res_valid, res_data, res_flags, ovf_count
  );
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: single-issue controller in front of an external combinational ALU.
// Holds a 4 x BW register file, launches one instruction at a time into the
// ALU, captures the result, writes it back and offers it on a valid/ready port.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : alu_ctrl_if.slave (instruction, ALU and result buses)
//
// state | meaning
// IDLE  | waiting for an instruction (instr_ready=1)
// EXEC  | operands at the ALU; capture result and write back this edge
// RESP  | result offered (res_valid=1) until res_ready
module alu_ctrl #(
  parameter int BW = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_accept;
  logic          w_capture;

  logic [BW-1:0] r_rf [4];
  logic [BW-1:0] r_alu_a;
  logic [BW-1:0] r_alu_b;
  logic [2:0]    r_alu_op;
  logic [1:0]    r_rd;
  logic [BW:0]   r_res_data;
  logic [2:0]    r_res_flags;
  logic [7:0]    r_ovf_count;

  logic          w_imm_sel;
  logic [2:0]    w_op;
  logic [1:0]    w_rd;
  logic [1:0]    w_ra;
  logic [1:0]    w_rb;

  assign w_imm_sel = bus.instr[9];
  assign w_op      = bus.instr[8:6];
  assign w_rd      = bus.instr[5:4];
  assign w_ra      = bus.instr[3:2];
  assign w_rb      = bus.instr[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.instr_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = EXEC;
        end
      end
      EXEC: begin
        w_capture   = 1'b1;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (bus.res_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operands are read at acceptance and the writeback happens one edge later,
  // so ra/rb/rd aliasing needs no special handling. rd is latched because the
  // instruction bus may change while the controller is busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
      r_rd     <= '0;
    end else if (w_accept) begin
      r_alu_a  <= r_rf[w_ra];
      r_alu_b  <= w_imm_sel ? bus.imm : r_rf[w_rb];
      r_alu_op <= w_op;
      r_rd     <= w_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) r_rf[i] <= '0;
      r_res_data  <= '0;
      r_res_flags <= '0;
    end else if (w_capture) begin
      r_rf[r_rd]  <= bus.alu_out[BW-1:0];
      r_res_data  <= bus.alu_out;
      r_res_flags <= bus.alu_flags;
    end
  end

  // Saturating: holds at 255 rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_count <= '0;
    end else if (w_capture && bus.alu_flags[2] && (r_ovf_count != 8'hFF)) begin
      r_ovf_count <= r_ovf_count + 8'd1;
    end
  end

  assign bus.instr_ready = (r_state == IDLE);
  assign bus.res_valid   = (r_state == RESP);
  assign bus.alu_a       = r_alu_a;
  assign bus.alu_b       = r_alu_b;
  assign bus.alu_op      = r_alu_op;
  assign bus.res_data    = r_res_data;
  assign bus.res_flags   = r_res_flags;
  assign bus.ovf_count   = r_ovf_count;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: drives alu_ctrl (BW=16) with a behavioural ALU attached,
// a register-file model and a result scoreboard queue.
module tb_alu_ctrl;
  localparam int BW = 16;

  logic clk;
  logic rst;

  alu_ctrl_if #(.BW(BW)) bus ();

  alu_ctrl #(.BW(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor,
  // 101 not a, 110 pass a, 111 pass b. Flags {ovf, neg, zero}; neg is the
  // true sign of the signed result, zero looks at the low BW bits.
  function automatic logic [19:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] op);
    logic [16:0] o;
    logic        v;
    v = 1'b0;
    o = '0;
    case (op)
      3'd0: begin o = {1'b0, a} + {1'b0, b}; v = (a[15] == b[15]) && (o[15] != a[15]); end
      3'd1: begin o = {1'b0, a} - {1'b0, b}; v = (a[15] != b[15]) && (o[15] != a[15]); end
      3'd2: o = {1'b0, a & b};
      3'd3: o = {1'b0, a | b};
      3'd4: o = {1'b0, a ^ b};
      3'd5: o = {1'b0, ~a};
      3'd6: o = {1'b0, a};
      default: o = {1'b0, b};
    endcase
    return {v, o[15] ^ v, (o[15:0] == 16'h0), o};
  endfunction

  logic [19:0] alu_res;
  assign alu_res       = alu_ref(bus.alu_a, bus.alu_b, bus.alu_op);
  assign bus.alu_out   = alu_res[16:0];
  assign bus.alu_flags = alu_res[19:17];

  typedef struct {
    logic        imm_sel;
    logic [2:0]  op;
    logic [1:0]  rd;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [15:0] imm;
    logic [16:0] exp_data;
    logic [2:0]  exp_flags;
  } vec_t;

  typedef struct {
    logic [1:0]  rd;
    logic [16:0] data;
    logic [2:0]  flags;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m_rf [4];
  int          m_ovf;
  int          checks;
  int          errors;

  function automatic vec_t mk(input logic s, input logic [2:0] op, input logic [1:0] rd,
                              input logic [1:0] ra, input logic [1:0] rb, input logic [15:0] imm,
                              input logic [16:0] d, input logic [2:0] f);
    vec_t v;
    v.imm_sel = s; v.op = op; v.rd = rd; v.ra = ra; v.rb = rb; v.imm = imm;
    v.exp_data = d; v.exp_flags = f;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.instr       = {v.imm_sel, v.op, v.rd, v.ra, v.rb};
    bus.imm         = v.imm;
    bus.instr_valid = 1'b1;
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 20 && !bus.instr_ready; n++) @(negedge clk);
    if (!bus.instr_ready) chk("ready_timeout", 32'(bus.instr_ready), 32'd1);
  endtask

  // Called 1 time unit after the acceptance edge.
  task automatic accept(input vec_t v, input bit use_ref);
    logic [15:0] a;
    logic [15:0] b;
    logic [19:0] r;
    exp_t        e;
    a = m_rf[v.ra];
    b = v.imm_sel ? v.imm : m_rf[v.rb];
    chk("alu_a", 32'(bus.alu_a), 32'(a));
    chk("alu_b", 32'(bus.alu_b), 32'(b));
    chk("alu_op", 32'(bus.alu_op), 32'(v.op));
    chk("busy_ready", 32'(bus.instr_ready), 32'd0);
    chk("exec_valid", 32'(bus.res_valid), 32'd0);
    e.rd = v.rd;
    if (use_ref) begin
      r       = alu_ref(a, b, v.op);
      e.data  = r[16:0];
      e.flags = r[19:17];
    end else begin
      e.data  = v.exp_data;
      e.flags = v.exp_flags;
    end
    sb_q.push_back(e);
  endtask

  // Called 1 time unit after the EXEC edge.
  task automatic result();
    exp_t e;
    chk("res_valid", 32'(bus.res_valid), 32'd1);
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("res_data", 32'(bus.res_data), 32'(e.data));
      chk("res_flags", 32'(bus.res_flags), 32'(e.flags));
      m_rf[e.rd] = e.data[15:0];
      if (e.flags[2] && m_ovf < 255) m_ovf++;
      chk("ovf_count", 32'(bus.ovf_count), 32'(m_ovf));
    end
  endtask

  task automatic finish_instr(input vec_t v, input bit use_ref);
    bus.instr_valid = 1'b0;
    accept(v, use_ref);
    @(posedge clk); #1;
    result();
    @(posedge clk); #1;
    chk("back_idle", 32'(bus.instr_ready), 32'd1);
  endtask

  task automatic run(input vec_t v, input bit use_ref);
    @(negedge clk);
    drive(v);
    wait_ready();
    @(posedge clk); #1;
    finish_instr(v, use_ref);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  vec_t tbl [12];
  vec_t va;
  vec_t vb;

  initial begin
    checks = 0;
    errors = 0;
    m_ovf  = 0;
    for (int i = 0; i < 4; i++) m_rf[i] = 16'h0;

    tbl[0]  = mk(1, 3'd7, 2'd1, 2'd0, 2'd0, 16'h7FFF, 17'h07FFF, 3'b000); // LI r1
    tbl[1]  = mk(1, 3'd7, 2'd2, 2'd0, 2'd0, 16'h0001, 17'h00001, 3'b000); // LI r2
    tbl[2]  = mk(0, 3'd0, 2'd3, 2'd1, 2'd2, 16'h0000, 17'h08000, 3'b100); // ADD ovf
    tbl[3]  = mk(1, 3'd7, 2'd1, 2'd0, 2'd0, 16'h1234, 17'h01234, 3'b000); // LI r1
    tbl[4]  = mk(0, 3'd1, 2'd0, 2'd1, 2'd1, 16'h0000, 17'h00000, 3'b001); // SUB r1-r1
    tbl[5]  = mk(0, 3'd2, 2'd0, 2'd1, 2'd3, 16'h0000, 17'h00000, 3'b001); // AND
    tbl[6]  = mk(0, 3'd3, 2'd2, 2'd1, 2'd3, 16'h0000, 17'h09234, 3'b010); // OR
    tbl[7]  = mk(0, 3'd4, 2'd2, 2'd2, 2'd2, 16'h0000, 17'h00000, 3'b001); // XOR aliased
    tbl[8]  = mk(1, 3'd7, 2'd0, 2'd0, 2'd0, 16'hFFFF, 17'h0FFFF, 3'b010); // LI r0
    tbl[9]  = mk(0, 3'd0, 2'd1, 2'd0, 2'd0, 16'h0000, 17'h1FFFE, 3'b010); // ADD -1+-1
    tbl[10] = mk(0, 3'd1, 2'd3, 2'd2, 2'd0, 16'h0000, 17'h10001, 3'b000); // SUB 0-(-1)
    tbl[11] = mk(1, 3'd0, 2'd2, 2'd1, 2'd0, 16'h0002, 17'h10000, 3'b001); // ADD imm

    // Reset with a valid instruction held: nothing may be accepted.
    rst             = 1'b1;
    bus.res_ready   = 1'b1;
    bus.instr       = {1'b1, 3'd7, 2'd1, 2'd0, 2'd0};
    bus.imm         = 16'hAAAA;
    bus.instr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
    chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_res_data", 32'(bus.res_data), 32'd0);
    chk("rst_res_flags", 32'(bus.res_flags), 32'd0);
    chk("rst_ovf", 32'(bus.ovf_count), 32'd0);

    // First edge after release accepts the pending instruction.
    va = mk(0, 3'd0, 2'd0, 2'd0, 2'd0, 16'h0000, 17'h00000, 3'b001);
    @(negedge clk);
    drive(va);
    rst = 1'b0;
    @(posedge clk); #1;
    finish_instr(va, 0);

    for (int i = 0; i < 12; i++) run(tbl[i], 0);

    // Back-pressure in RESP with the next instruction already pending.
    va = mk(0, 3'd3, 2'd3, 2'd1, 2'd1, 16'h0000, 17'h0FFFE, 3'b010);
    vb = mk(1, 3'd7, 2'd0, 2'd0, 2'd0, 16'h5A5A, 17'h05A5A, 3'b000);
    @(negedge clk);
    bus.res_ready = 1'b0;
    drive(va);
    wait_ready();
    @(posedge clk); #1;
    accept(va, 0);
    drive(vb);
    @(posedge clk); #1;
    result();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus.res_valid), 32'd1);
      chk("hold_data", 32'(bus.res_data), 32'h0FFFE);
      chk("hold_flags", 32'(bus.res_flags), 32'b010);
      chk("hold_ready", 32'(bus.instr_ready), 32'd0);
    end
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", 32'(bus.instr_ready), 32'd1);
    chk("release_valid", 32'(bus.res_valid), 32'd0);
    @(posedge clk); #1;
    finish_instr(vb, 0);

    // Reset during EXEC aborts the load-immediate.
    run(mk(1, 3'd7, 2'd2, 2'd0, 2'd0, 16'h0001, 17'h00001, 3'b000), 0);
    va = mk(1, 3'd7, 2'd2, 2'd0, 2'd0, 16'hBEEF, 17'h0BEEF, 3'b010);
    @(negedge clk);
    drive(va);
    wait_ready();
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    accept(va, 0);
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", 32'(bus.res_valid), 32'd0);
    chk("abort_ready", 32'(bus.instr_ready), 32'd1);
    chk("abort_alu_b", 32'(bus.alu_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = 16'h0;
    m_ovf = 0;
    sb_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("abort_no_resp", 32'(bus.res_valid), 32'd0);
    end
    run(mk(0, 3'd0, 2'd3, 2'd2, 2'd2, 16'h0000, 17'h00000, 3'b001), 0);

    // Overflow counter saturation.
    run(mk(1, 3'd7, 2'd1, 2'd0, 2'd0, 16'h7FFF, 17'h07FFF, 3'b000), 0);
    run(mk(1, 3'd7, 2'd2, 2'd0, 2'd0, 16'h0001, 17'h00001, 3'b000), 0);
    for (int i = 0; i < 260; i++) run(mk(0, 3'd0, 2'd3, 2'd1, 2'd2, 16'h0, 17'h0, 3'b0), 1);
    chk("ovf_sat", 32'(bus.ovf_count), 32'd255);
    run(mk(0, 3'd4, 2'd3, 2'd1, 2'd2, 16'h0000, 17'h07FFE, 3'b000), 0);
    chk("ovf_sat_after_xor", 32'(bus.ovf_count), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
